// File: rtl/memory_stage.sv
// LEGv8 memory stage: EX/MEM register, CBZ resolution and a req/ack data-memory port
// with a bounded wait. Execute is stalled while an access is outstanding.
module memory_stage #(
  parameter int unsigned N       = 64,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_E,
  input  logic         Branch_E,
  input  logic         memRead_E,
  input  logic         memWrite_E,
  input  logic         flush_M,
  input  logic [N-1:0] aluResult_E,
  input  logic [N-1:0] writeData_E,
  input  logic [N-1:0] PCBranch_E,
  input  logic         zero_E,
  output logic         stall_E,
  output logic         dm_req,
  output logic         dm_we,
  output logic [N-1:0] dm_addr,
  output logic [N-1:0] dm_wdata,
  input  logic         dm_ack,
  input  logic [N-1:0] dm_rdata,
  output logic         PCSrc_M,
  output logic [N-1:0] PCBranch_M,
  output logic [N-1:0] aluResult_M,
  output logic [N-1:0] readData_M,
  output logic         done_M,
  output logic         err_M
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CntLast = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StRun, StMem, StDone} state_e;

  state_e         r_state;
  state_e         w_state_next;
  logic           r_valid;
  logic           r_branch;
  logic           r_mem_read;
  logic           r_mem_write;
  logic           r_zero;
  logic [N-1:0]   r_alu_result;
  logic [N-1:0]   r_write_data;
  logic [N-1:0]   r_pc_branch;
  logic [N-1:0]   r_read_data;
  logic [CW-1:0]  r_cnt;
  logic           r_err;
  logic           w_capture;
  logic           w_memop_e;
  logic           w_cnt_last;

  // A memory op heads straight into MEM at its capture edge so the access starts next cycle.
  assign w_memop_e  = valid_E & ~flush_M & (memRead_E | memWrite_E);
  assign w_capture  = (r_state != StMem);
  assign w_cnt_last = (r_cnt == CntLast);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StRun;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StRun:   w_state_next = w_memop_e ? StMem : StRun;
      StMem:   if (dm_ack || w_cnt_last) w_state_next = StDone;
      StDone:  w_state_next = w_memop_e ? StMem : StRun;
      default: w_state_next = StRun;
    endcase
  end

  always_comb begin
    stall_E = 1'b0;
    dm_req  = 1'b0;
    done_M  = 1'b0;
    err_M   = 1'b0;
    unique case (r_state)
      StRun:   done_M = r_valid;
      StMem: begin
        stall_E = 1'b1;
        dm_req  = 1'b1;
      end
      StDone: begin
        done_M = 1'b1;
        err_M  = r_err;
      end
      default: done_M = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid      <= 1'b0;
      r_branch     <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_zero       <= 1'b0;
      r_alu_result <= '0;
      r_write_data <= '0;
      r_pc_branch  <= '0;
      r_read_data  <= '0;
      r_cnt        <= '0;
      r_err        <= 1'b0;
    end else begin
      if (w_capture) begin
        r_valid      <= valid_E & ~flush_M;
        r_branch     <= Branch_E;
        r_mem_read   <= memRead_E;
        r_mem_write  <= memWrite_E;
        r_zero       <= zero_E;
        r_alu_result <= aluResult_E;
        r_write_data <= writeData_E;
        r_pc_branch  <= PCBranch_E;
      end
      if (r_state == StMem) begin
        r_cnt <= r_cnt + 1'b1;
        // Ack beats a coincident timeout; a read+write op is treated as a store.
        if (dm_ack) begin
          if (r_mem_read && !r_mem_write) begin
            r_read_data <= dm_rdata;
          end
        end else if (w_cnt_last) begin
          r_read_data <= '0;
          r_err       <= 1'b1;
        end
      end else if (r_state == StDone) begin
        r_cnt <= '0;
        r_err <= 1'b0;
      end
    end
  end

  assign dm_we       = r_mem_write & dm_req;
  assign dm_addr     = r_alu_result;
  assign dm_wdata    = r_write_data;
  assign PCSrc_M     = r_valid & r_branch & r_zero;
  assign PCBranch_M  = r_pc_branch;
  assign aluResult_M = r_alu_result;
  assign readData_M  = r_read_data;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage with a transaction-level reference model checked every cycle.
module tb_memory_stage;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_E, Branch_E, memRead_E, memWrite_E, flush_M, zero_E;
  logic [63:0] aluResult_E, writeData_E, PCBranch_E;
  logic        stall_E, dm_req, dm_we, dm_ack;
  logic [63:0] dm_addr, dm_wdata, dm_rdata;
  logic        PCSrc_M, done_M, err_M;
  logic [63:0] PCBranch_M, aluResult_M, readData_M;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  memory_stage #(.N(64), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .valid_E(valid_E), .Branch_E(Branch_E),
    .memRead_E(memRead_E), .memWrite_E(memWrite_E), .flush_M(flush_M),
    .aluResult_E(aluResult_E), .writeData_E(writeData_E), .PCBranch_E(PCBranch_E),
    .zero_E(zero_E), .stall_E(stall_E), .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .PCSrc_M(PCSrc_M), .PCBranch_M(PCBranch_M), .aluResult_M(aluResult_M),
    .readData_M(readData_M), .done_M(done_M), .err_M(err_M)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, want %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the instruction held in M, whether its access is outstanding,
  // how many request cycles it has used, and whether this cycle retires it.
  logic        mv = 0, mbr = 0, mrd = 0, mwr = 0, mz = 0;
  logic [63:0] malu = 0, mwd = 0, mpc = 0, m_rdata = 0;
  logic        m_out = 0, m_ret = 0, m_err = 0;
  int          m_wait = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mv <= 0; mbr <= 0; mrd <= 0; mwr <= 0; mz <= 0;
      malu <= 0; mwd <= 0; mpc <= 0; m_rdata <= 0;
      m_out <= 0; m_ret <= 0; m_err <= 0; m_wait <= 0;
    end else if (m_out) begin
      m_wait <= m_wait + 1;
      if (dm_ack) begin
        if (mrd && !mwr) m_rdata <= dm_rdata;
        m_out <= 0; m_ret <= 1; m_err <= 0;
      end else if (m_wait + 1 == TO) begin
        m_rdata <= 0;
        m_out <= 0; m_ret <= 1; m_err <= 1;
      end
    end else begin
      m_ret  <= 0;
      m_err  <= 0;
      mv     <= valid_E && !flush_M;
      mbr    <= Branch_E;
      mrd    <= memRead_E;
      mwr    <= memWrite_E;
      mz     <= zero_E;
      malu   <= aluResult_E;
      mwd    <= writeData_E;
      mpc    <= PCBranch_E;
      m_out  <= valid_E && !flush_M && (memRead_E || memWrite_E);
      m_wait <= 0;
    end
  end

  always @(negedge clk) begin
    chk1("model stall_E", stall_E, m_out);
    chk1("model dm_req", dm_req, m_out);
    chk1("model dm_we", dm_we, m_out && mwr);
    chk("model dm_addr", dm_addr, malu);
    chk("model dm_wdata", dm_wdata, mwd);
    chk1("model PCSrc_M", PCSrc_M, mv && mbr && mz);
    chk("model PCBranch_M", PCBranch_M, mpc);
    chk("model aluResult_M", aluResult_M, malu);
    chk("model readData_M", readData_M, m_rdata);
    chk1("model done_M", done_M, m_ret || (!m_out && mv && !(mrd || mwr)));
    chk1("model err_M", err_M, m_ret && m_err);
  end

  task automatic set_inst(input logic v, br, rd, wr, fl, input logic [63:0] alu, wd, pcb,
                          input logic z);
    valid_E = v; Branch_E = br; memRead_E = rd; memWrite_E = wr; flush_M = fl;
    aluResult_E = alu; writeData_E = wd; PCBranch_E = pcb; zero_E = z;
  endtask

  // Issues one memory op, then presents a follow-up ALU op (or a bubble if follow_alu is 0)
  // and answers requests, acking in request cycle ack_at (0 = never). Returns at the
  // falling edge where done_M is expected.
  task automatic run_mem(input logic rd, wr, input logic [63:0] alu, wd, input int ack_at,
                         input logic [63:0] rdata, input logic [63:0] follow_alu,
                         output int reqs, output int stalls, output logic [63:0] a_addr,
                         output logic [63:0] a_wdata, output logic a_we);
    set_inst(1, 0, rd, wr, 0, alu, wd, 0, 0);
    @(negedge clk);
    set_inst(follow_alu != 0, 0, 0, 0, 0, follow_alu, 0, 0, 0);
    reqs = 0; stalls = 0; a_addr = 0; a_wdata = 0; a_we = 0;
    for (int i = 0; i < 3 * TO && !done_M; i++) begin
      if (dm_req) begin
        reqs++;
        if (reqs == 1) begin
          a_addr = dm_addr; a_wdata = dm_wdata; a_we = dm_we;
        end
      end
      if (stall_E) stalls++;
      dm_ack   = dm_req && ack_at != 0 && reqs == ack_at;
      dm_rdata = dm_ack ? rdata : {$urandom, $urandom};
      @(negedge clk);
    end
    dm_ack = 0;
    chk1("memop retired within bound", done_M, 1'b1);
  endtask

  int          reqs, stalls;
  logic [63:0] a_addr, a_wdata;
  logic        a_we;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_inst(0, 0, 0, 0, 0, 0, 0, 0, 0);
    dm_ack = 0; dm_rdata = 0;
    reset = 1;
    #1 reset = 0;
    @(negedge clk);
    chk1("reset done_M", done_M, 1'b0);
    chk1("reset dm_req", dm_req, 1'b0);
    chk("reset aluResult_M", aluResult_M, 64'd0);
    reset = 1;

    // ALU op, with a stray ack that must be ignored outside MEM
    set_inst(1, 0, 0, 0, 0, 64'd14, 0, 0, 0);
    dm_ack = 1; dm_rdata = 64'h5555;
    @(negedge clk);
    dm_ack = 0;
    chk("alu aluResult_M", aluResult_M, 64'd14);
    chk1("alu done_M", done_M, 1'b1);
    chk1("alu stall_E", stall_E, 1'b0);
    chk1("alu dm_req", dm_req, 1'b0);
    chk("alu stray ack readData_M", readData_M, 64'd0);

    // CBZ taken, not taken, flushed
    set_inst(1, 1, 0, 0, 0, 0, 0, 64'd104, 1);
    @(negedge clk);
    chk1("cbz taken PCSrc_M", PCSrc_M, 1'b1);
    chk("cbz PCBranch_M", PCBranch_M, 64'd104);
    set_inst(1, 1, 0, 0, 0, 0, 0, 64'd104, 0);
    @(negedge clk);
    chk1("cbz not-taken PCSrc_M", PCSrc_M, 1'b0);
    set_inst(1, 1, 0, 0, 1, 0, 0, 64'd104, 1);
    @(negedge clk);
    chk1("cbz flushed PCSrc_M", PCSrc_M, 1'b0);
    chk1("cbz flushed done_M", done_M, 1'b0);
    set_inst(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);

    // Load, acked in the 3rd request cycle
    run_mem(1, 0, 64'h40, 0, 3, 64'hDEADBEEF, 0, reqs, stalls, a_addr, a_wdata, a_we);
    chk("load req cycles", 64'(reqs), 64'd3);
    chk("load stall cycles", 64'(stalls), 64'd3);
    chk("load dm_addr", a_addr, 64'h40);
    chk1("load dm_we", a_we, 1'b0);
    chk1("load err_M", err_M, 1'b0);
    chk("load readData_M", readData_M, 64'hDEADBEEF);
    @(negedge clk);
    chk1("load done pulse ends", done_M, 1'b0);

    // Store with immediate ack, followed back-to-back by an ALU op
    run_mem(0, 1, 64'd8, 64'd20, 1, 64'h77, 64'd6, reqs, stalls, a_addr, a_wdata, a_we);
    chk("store req cycles", 64'(reqs), 64'd1);
    chk1("store dm_we", a_we, 1'b1);
    chk("store dm_wdata", a_wdata, 64'd20);
    chk("store dm_addr", a_addr, 64'd8);
    chk("store keeps readData_M", readData_M, 64'hDEADBEEF);
    @(negedge clk);
    set_inst(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk1("follow-up alu done_M", done_M, 1'b1);
    chk("follow-up aluResult_M", aluResult_M, 64'd6);
    @(negedge clk);
    chk1("follow-up retires once", done_M, 1'b0);

    // Timeout with no ack, then ack in the last allowed cycle
    run_mem(1, 0, 64'h80, 0, 0, 0, 0, reqs, stalls, a_addr, a_wdata, a_we);
    chk("timeout req cycles", 64'(reqs), 64'd4);
    chk1("timeout err_M", err_M, 1'b1);
    chk("timeout readData_M", readData_M, 64'd0);
    @(negedge clk);
    chk1("timeout err pulse ends", err_M, 1'b0);
    run_mem(1, 0, 64'h88, 0, 4, 64'h1234, 0, reqs, stalls, a_addr, a_wdata, a_we);
    chk("late ack req cycles", 64'(reqs), 64'd4);
    chk1("late ack err_M", err_M, 1'b0);
    chk("late ack readData_M", readData_M, 64'h1234);
    @(negedge clk);

    // Reset during the 2nd MEM cycle
    set_inst(1, 0, 1, 0, 0, 64'h90, 0, 0, 0);
    @(negedge clk);
    set_inst(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk1("pre-reset dm_req", dm_req, 1'b1);
    @(negedge clk);
    #2 reset = 0;
    #1;
    chk1("mid reset dm_req", dm_req, 1'b0);
    chk1("mid reset stall_E", stall_E, 1'b0);
    chk1("mid reset done_M", done_M, 1'b0);
    chk("mid reset dm_addr", dm_addr, 64'd0);
    chk("mid reset readData_M", readData_M, 64'd0);
    @(negedge clk);
    chk1("held reset done_M", done_M, 1'b0);
    reset = 1;
    set_inst(1, 0, 0, 0, 0, 64'd33, 0, 0, 0);
    @(negedge clk);
    set_inst(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk1("post-reset alu done_M", done_M, 1'b1);
    chk("post-reset aluResult_M", aluResult_M, 64'd33);
    @(negedge clk);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
# memory_stage

Memory stage of the pipelined LEGv8 datapath, sitting directly downstream of `execute`. It captures the execute-stage results (`aluResult_E`, `writeData_E`, `zero_E`, `PCBranch_E`) plus the memory and branch controls into an EX/MEM register. It resolves CBZ branches (`PCSrc_M`) and runs loads and stores against a variable-latency data memory using a req/ack handshake. While an access is outstanding it back-pressures execute through `stall_E`.

## Interface
- `N`, default 64: datapath width.
- `TIMEOUT`, default 15: maximum wait cycles for `dm_ack` before the access is aborted.

- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `valid_E` input 1: execute holds a real instruction (0 = bubble).
- `Branch_E` input 1: instruction is CBZ.
- `memRead_E` input 1: instruction is a load (LDUR).
- `memWrite_E` input 1: instruction is a store (STUR).
- `flush_M` input 1: discard the instruction captured at this edge.
- `aluResult_E` input N: ALU result, which is also the memory address.
- `writeData_E` input N: store data.
- `PCBranch_E` input N: branch target.
- `zero_E` input 1: ALU zero flag.
- `stall_E` output 1: execute must hold its outputs.
- `dm_req` output 1: memory access request.
- `dm_we` output 1: 1 = write.
- `dm_addr` output N: access address.
- `dm_wdata` output N: write data.
- `dm_ack` input 1: memory completed the request.
- `dm_rdata` input N: read data, valid when `dm_ack`=1.
- `PCSrc_M` output 1: take branch.
- `PCBranch_M` output N: registered branch target.
- `aluResult_M` output N: registered ALU result.
- `readData_M` output N: load data.
- `done_M` output 1: one-cycle pulse when the instruction in M retires.
- `err_M` output 1: one-cycle pulse, coincident with `done_M`, on timeout abort.

## Operation
- **EX/MEM register.** Fields: `valid_M`, `Branch_M`, `memRead_M`, `memWrite_M`, `zero_M`, `aluResult_M`, `writeData_M`, `PCBranch_M`.
  - Loads on every rising edge while state is not MEM.
  - If `flush_M`=1 at that edge, `valid_M` loads 0; the other fields load normally.
- **Memory op.** `memop_M` = `valid_M` & (`memRead_M` | `memWrite_M`). If both read and write are set, the access is a write.
- **FSM states:** RUN, MEM, DONE.
  - RUN: if `memop_M`=1, go to MEM next edge. Otherwise `done_M` = `valid_M` this cycle and stay in RUN.
  - MEM: `dm_req`=1 and `stall_E`=1. The wait counter increments each cycle.
    - On `dm_ack`=1: latch `readData_M` = `dm_rdata` (loads only; unchanged for stores) and go to DONE.
    - Else, if the counter = TIMEOUT-1: set `readData_M`=0, set the error flag, and go to DONE.
  - DONE: `done_M`=1, plus `err_M`=1 if the error flag is set. Clear the flag and counter, go to RUN. The register captures the next instruction at this edge.
- **Memory outputs.** `dm_addr` = `aluResult_M`, `dm_wdata` = `writeData_M`, `dm_we` = `memWrite_M` & `dm_req`. When `dm_req`=0, these are held at the register values and `dm_we`=0.
- **Branch.** `PCSrc_M` = `valid_M` & `Branch_M` & `zero_M`, combinational from the register. `PCBranch_M` is the registered value.
- **`stall_E`** = (state == MEM), purely combinational from state.

## Timing
- **Reset** (asynchronous, immediate): all register fields 0, state RUN, counter 0, error flag 0, `readData_M`=0. Every output is therefore 0 during and after reset until the first capture.
- **Non-memory instruction:** captured at edge n; `done_M`, `aluResult_M` and `PCSrc_M` are valid during cycle n+1. Throughput is 1 per cycle.
- **Memory instruction:** captured at edge n.
  - MEM spans cycles n+1 through the ack cycle k.
  - DONE is cycle k+1, with `done_M`=1.
  - The next instruction is captured at the end of k+1.
  - Minimum latency (ack in the first MEM cycle) is 2 cycles from capture to `done_M`.
- **Ack rules:**
  - `dm_ack` outside MEM is ignored.
  - `dm_ack` in the same cycle the timeout is reached: ack wins, no error.
- **Timeout:** `dm_req` is high for exactly TIMEOUT cycles, then DONE with `err_M`=1.
- **Flush during MEM** has no effect: the outstanding access always completes or times out.
- **Reset mid-access:** `dm_req` drops asynchronously and no `done_M` is issued.
- Execute must hold its outputs stable while `stall_E`=1.

## Test plan
- **ALU op, no memory:** `valid_E`=1, `aluResult_E`=14. Expect `aluResult_M`=14 and `done_M`=1 in the next cycle; `stall_E` and `dm_req` stay 0.
- **CBZ:**
  - `Branch_E`=1, `zero_E`=1, `PCBranch_E`=104: expect `PCSrc_M`=1 and `PCBranch_M`=104 the next cycle.
  - Repeat with `zero_E`=0: expect `PCSrc_M`=0.
  - Repeat with `flush_M`=1: expect `PCSrc_M`=0 and no `done_M`.
- **Load, 3-cycle memory:** `aluResult_E`=0x40, memory acks in its 3rd request cycle with `dm_rdata`=0xDEADBEEF. Expect:
  - `dm_addr`=0x40 and `dm_we`=0.
  - `dm_req` and `stall_E` high for 3 cycles.
  - `done_M` one cycle after the ack, with `readData_M`=0xDEADBEEF.
- **Store, immediate ack:** `writeData_E`=20, `aluResult_E`=8. Expect `dm_req`=`dm_we`=1 for 1 cycle with `dm_wdata`=20 and `dm_addr`=8, then `done_M` the next cycle. A back-to-back ALU op (result 6) retires 1 cycle later.
- **Timeout (TIMEOUT=4), no ack:** expect `dm_req` high exactly 4 cycles, then `done_M`=`err_M`=1 with `readData_M`=0. Second run: ack in the 4th cycle gives `err_M`=0.
- **Reset mid-access:** assert `reset`=0 during the 2nd MEM cycle. Expect `dm_req` and `stall_E` to drop immediately, all outputs 0, and normal retirement of the next ALU op after release.
